// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter that gives NUM_REQ requesters one-at-a-time write access
// to a shared bank of negative-edge JK flip-flops (hold/clear/set/toggle under a bit mask).
module jk_bank_arbiter #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4
) (
    input  logic                     Clk_In,
    input  logic                     Reset_In,
    input  logic [NUM_REQ-1:0]       Req_In,
    input  logic [2*NUM_REQ-1:0]     Op_In,
    input  logic [WIDTH*NUM_REQ-1:0] Mask_In,
    output logic [NUM_REQ-1:0]       Grant_Out,
    output logic [NUM_REQ-1:0]       Done_Out,
    output logic                     Busy_Out,
    output logic [WIDTH-1:0]         Q_Out
);
    localparam int          PW   = $clog2(NUM_REQ);
    localparam logic [PW:0] NREQ = (PW+1)'(NUM_REQ);

    typedef enum logic [1:0] {IDLE, APPLY, COMMIT} state_t;

    state_t               r_state, w_stateNext;
    logic [PW-1:0]        r_ptr, w_ptrNext;
    logic [PW-1:0]        r_winner, w_winnerNext;
    logic [1:0]           r_op, w_opNext;
    logic [WIDTH-1:0]     r_mask, w_maskNext;
    logic [NUM_REQ-1:0]   r_grant, w_grantNext;
    logic [NUM_REQ-1:0]   r_done, w_doneNext;
    logic [WIDTH-1:0]     r_q;
    logic                 w_found;
    logic [PW-1:0]        w_win;
    logic [WIDTH-1:0]     w_j, w_k;

    function automatic logic [PW-1:0] wrapIdx(input logic [PW-1:0] base, input int offs);
        logic [PW:0] sum;
        sum = {1'b0, base} + (PW+1)'(offs);
        if (sum >= NREQ) sum = sum - NREQ;
        return sum[PW-1:0];
    endfunction

    // Scan downward so the requester closest to the pointer is the last to overwrite the winner
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (Req_In[wrapIdx(r_ptr, i)]) begin
                w_found = 1'b1;
                w_win   = wrapIdx(r_ptr, i);
            end
        end
    end

    always_comb begin
        w_stateNext  = r_state;
        w_ptrNext    = r_ptr;
        w_winnerNext = r_winner;
        w_opNext     = r_op;
        w_maskNext   = r_mask;
        w_grantNext  = r_grant;
        w_doneNext   = '0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_stateNext  = APPLY;
                    w_winnerNext = w_win;
                    w_opNext     = Op_In[2*w_win +: 2];
                    w_maskNext   = Mask_In[WIDTH*w_win +: WIDTH];
                    w_grantNext  = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;
                end
            end
            APPLY: begin
                w_stateNext = COMMIT;
                w_doneNext  = r_grant;
            end
            COMMIT: begin
                w_stateNext = IDLE;
                w_grantNext = '0;
                w_ptrNext   = wrapIdx(r_winner, 1);
            end
            default: begin
                w_stateNext = IDLE;
                w_grantNext = '0;
            end
        endcase
    end

    always_ff @(posedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_winner <= '0;
            r_op     <= '0;
            r_mask   <= '0;
            r_grant  <= '0;
            r_done   <= '0;
        end else begin
            r_state  <= w_stateNext;
            r_ptr    <= w_ptrNext;
            r_winner <= w_winnerNext;
            r_op     <= w_opNext;
            r_mask   <= w_maskNext;
            r_grant  <= w_grantNext;
            r_done   <= w_doneNext;
        end
    end

    // J/K come only from registers, so they are settled well before the capturing negedge
    assign w_j = (r_state == APPLY && r_op[1]) ? r_mask : '0;
    assign w_k = (r_state == APPLY && r_op[0]) ? r_mask : '0;

    always_ff @(negedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            r_q <= '0;
        end else begin
            r_q <= (r_q & ~(w_j | w_k)) | (w_j & ~w_k) | (w_j & w_k & ~r_q);
        end
    end

    assign Grant_Out = r_grant;
    assign Done_Out  = r_done;
    assign Busy_Out  = (r_state != IDLE);
    assign Q_Out     = r_q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Scoreboard bench for jk_bank_arbiter: each granted operation pushes its expected
// Done one-hot and bank value, popped when the DUT pulses Done.
module tb_jk_bank_arbiter;
    localparam int WIDTH   = 8;
    localparam int NUM_REQ = 4;

    logic                     Clk_In;
    logic                     Reset_In;
    logic [NUM_REQ-1:0]       Req_In;
    logic [2*NUM_REQ-1:0]     Op_In;
    logic [WIDTH*NUM_REQ-1:0] Mask_In;
    logic [NUM_REQ-1:0]       Grant_Out;
    logic [NUM_REQ-1:0]       Done_Out;
    logic                     Busy_Out;
    logic [WIDTH-1:0]         Q_Out;

    typedef struct {
        logic [NUM_REQ-1:0] done;
        logic [WIDTH-1:0]   q;
    } expect_t;

    expect_t    scb[$];
    expect_t    monExp;
    int         errCount   = 0;
    int         checkCount = 0;
    int         cyc        = 0;
    logic [7:0] qModel     = '0;

    jk_bank_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
        .Clk_In    (Clk_In),
        .Reset_In  (Reset_In),
        .Req_In    (Req_In),
        .Op_In     (Op_In),
        .Mask_In   (Mask_In),
        .Grant_Out (Grant_Out),
        .Done_Out  (Done_Out),
        .Busy_Out  (Busy_Out),
        .Q_Out     (Q_Out)
    );

    initial begin
        Clk_In = 1'b0;
        forever #5 Clk_In = ~Clk_In;
    end

    always @(posedge Clk_In) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic logic [7:0] bankModel(input logic [7:0] q, input logic [1:0] op, input logic [7:0] mask);
        logic [7:0] r;
        r = q;
        for (int b = 0; b < WIDTH; b++) begin
            if (mask[b]) begin
                case (op)
                    2'b01:   r[b] = 1'b0;
                    2'b10:   r[b] = 1'b1;
                    2'b11:   r[b] = ~q[b];
                    default: r[b] = q[b];
                endcase
            end
        end
        return r;
    endfunction

    // Completion monitor: every Done pulse must match the oldest outstanding expectation
    always @(posedge Clk_In) begin
        #1;
        if (Done_Out != '0) begin
            if (scb.size() == 0) begin
                checkOutput("unexpected_done", 32'(Done_Out), 32'h0);
            end else begin
                monExp = scb.pop_front();
                checkOutput("done", 32'(Done_Out), 32'(monExp.done));
                checkOutput("grant_at_done", 32'(Grant_Out), 32'(monExp.done));
                checkOutput("q_at_done", 32'(Q_Out), 32'(monExp.q));
            end
        end
    end

    // Raises one request and returns just after the edge that grants it, with Req dropped
    task automatic applyStimulus(input int idx, input logic [1:0] op, input logic [7:0] mask, output bit granted);
        granted = 1'b0;
        @(negedge Clk_In);
        Req_In[idx]           = 1'b1;
        Op_In[2*idx +: 2]     = op;
        Mask_In[WIDTH*idx +: WIDTH] = mask;
        for (int c = 0; c < 10 && !granted; c++) begin
            @(posedge Clk_In);
            #1;
            if (Grant_Out != '0) granted = 1'b1;
        end
        if (!granted) checkOutput("grant_timeout", 32'h0, 32'h1);
        Req_In[idx] = 1'b0;
    endtask

    task automatic runOp(input int idx, input logic [1:0] op, input logic [7:0] mask, input bit lateChange);
        bit                 granted;
        logic [NUM_REQ-1:0] oneHot;
        oneHot = 4'b0001 << idx;
        qModel = bankModel(qModel, op, mask);
        scb.push_back('{done: oneHot, q: qModel});
        applyStimulus(idx, op, mask, granted);
        checkOutput("grant", 32'(Grant_Out), 32'(oneHot));
        checkOutput("busy_apply", 32'(Busy_Out), 32'h1);
        if (lateChange) begin
            Op_In[2*idx +: 2]           = ~op;
            Mask_In[WIDTH*idx +: WIDTH] = 8'hFF;
        end
        @(negedge Clk_In);
        #1;
        checkOutput("q_apply_negedge", 32'(Q_Out), 32'(qModel));
        @(posedge Clk_In);
        @(posedge Clk_In);
        #2;
        checkOutput("grant_idle", 32'(Grant_Out), 32'h0);
        checkOutput("busy_idle", 32'(Busy_Out), 32'h0);
        checkOutput("done_idle", 32'(Done_Out), 32'h0);
        checkOutput("scb_drained", 32'(scb.size()), 32'h0);
    endtask

    initial begin
        int   order[5] = '{0, 1, 2, 3, 0};
        int   nGrant;
        int   lastCyc;
        bit   granted;
        logic [NUM_REQ-1:0] prevGrant;

        Reset_In = 1'b1;
        Req_In   = '0;
        Op_In    = '0;
        Mask_In  = '0;
        #1;
        checkOutput("reset_grant", 32'(Grant_Out), 32'h0);
        checkOutput("reset_done", 32'(Done_Out), 32'h0);
        checkOutput("reset_busy", 32'(Busy_Out), 32'h0);
        checkOutput("reset_q", 32'(Q_Out), 32'h0);
        repeat (2) @(negedge Clk_In);
        Reset_In = 1'b0;
        repeat (3) @(posedge Clk_In);
        #1;
        checkOutput("idle_busy", 32'(Busy_Out), 32'h0);
        checkOutput("idle_grant", 32'(Grant_Out), 32'h0);

        runOp(0, 2'b10, 8'h0F, 1'b0);
        runOp(2, 2'b11, 8'hAA, 1'b0);
        runOp(2, 2'b11, 8'hAA, 1'b0);
        runOp(1, 2'b01, 8'h05, 1'b1);
        runOp(3, 2'b11, 8'h00, 1'b0);
        runOp(0, 2'b00, 8'hFF, 1'b0);

        // Contention: all four requesting straight out of reset
        @(negedge Clk_In);
        Reset_In = 1'b1;
        Req_In   = 4'hF;
        for (int i = 0; i < NUM_REQ; i++) begin
            Op_In[2*i +: 2]           = 2'b10;
            Mask_In[WIDTH*i +: WIDTH] = 8'h01 << i;
        end
        qModel = '0;
        for (int n = 0; n < 5; n++) begin
            qModel = bankModel(qModel, 2'b10, 8'h01 << order[n]);
            scb.push_back('{done: 4'b0001 << order[n], q: qModel});
        end
        @(negedge Clk_In);
        Reset_In  = 1'b0;
        prevGrant = '0;
        nGrant    = 0;
        lastCyc   = 0;
        for (int c = 0; c < 30 && nGrant < 5; c++) begin
            @(posedge Clk_In);
            #1;
            if (Grant_Out != '0 && prevGrant == '0) begin
                checkOutput("cont_grant", 32'(Grant_Out), 32'(4'b0001 << order[nGrant]));
                if (nGrant > 0) checkOutput("cont_spacing", 32'(cyc - lastCyc), 32'd3);
                lastCyc = cyc;
                nGrant++;
                if (nGrant == 5) Req_In = '0;
            end
            prevGrant = Grant_Out;
        end
        checkOutput("cont_grant_count", 32'(nGrant), 32'd5);
        repeat (3) @(posedge Clk_In);
        #2;
        checkOutput("cont_scb_drained", 32'(scb.size()), 32'h0);

        // Reset landing inside APPLY, after the bank has already captured the set
        applyStimulus(0, 2'b10, 8'hFF, granted);
        checkOutput("rst_grant", 32'(Grant_Out), 32'h1);
        @(negedge Clk_In);
        #1;
        checkOutput("rst_q_before", 32'(Q_Out), 32'hFF);
        #1;
        Reset_In = 1'b1;
        #1;
        checkOutput("rst_q", 32'(Q_Out), 32'h0);
        checkOutput("rst_grant_clr", 32'(Grant_Out), 32'h0);
        checkOutput("rst_busy_clr", 32'(Busy_Out), 32'h0);
        checkOutput("rst_done_clr", 32'(Done_Out), 32'h0);
        @(negedge Clk_In);
        Reset_In = 1'b0;
        qModel   = '0;
        runOp(3, 2'b10, 8'h3C, 1'b0);

        repeat (4) @(posedge Clk_In);
        #2;
        checkOutput("final_scb_empty", 32'(scb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule

// File: doc/jk_bank_arbiter.md
# jk_bank_arbiter

Round-robin arbiter that shares one WIDTH-bit bank of negative-edge JK flip-flops among NUM_REQ requesters. Each requester asks for one bank operation (hold, clear, set or toggle) applied to a bit mask. The arbiter grants one requester at a time, drives the per-bit J/K inputs for exactly one clock, then returns a completion pulse. It is the single write path into the shared JK status/flag bank.

## Interface
- WIDTH, 8, number of JK flip-flops in the bank.
- NUM_REQ, 4, number of requesters; at least 2.
- Clk_In  input  1  clock; arbiter logic on posedge, bank flip-flops on negedge.
- Reset_In  input  1  reset, asynchronous, active-high.
- Req_In  input  NUM_REQ  per-requester request level.
- Op_In  input  2*NUM_REQ  per-requester {J,K} code in slice [2i+1:2i]:
  - 00 hold, 01 clear, 10 set, 11 toggle.
- Mask_In  input  WIDTH*NUM_REQ  per-requester bit mask in slice [WIDTH*i +: WIDTH]; 1 = bit affected.
- Grant_Out  output  NUM_REQ  one-hot grant; high in APPLY and COMMIT.
- Done_Out  output  NUM_REQ  one-hot, one-cycle completion pulse in COMMIT.
- Busy_Out  output  1  high whenever state is not IDLE.
- Q_Out  output  WIDTH  bank contents.

## Operation
- FSM states:
  - IDLE: when any Req_In bit is high, select the winner, latch its Op and Mask, register the one-hot grant, and go to APPLY. Otherwise stay in IDLE.
  - APPLY: drive J/K. Go to COMMIT unconditionally.
  - COMMIT: pulse Done for the winner, set pointer = (winner+1) mod NUM_REQ, and go to IDLE.
- Winner selection: first requester with Req high, searching upward from the rotating pointer and wrapping from NUM_REQ-1 to 0.
- Bank drive during APPLY:
  - For each bit b: {J[b],K[b]} = Mask_lat[b] ? Op_lat : 2'b00.
  - In every other state, all J/K = 00.
  - Unmasked bits never change.
- Bank bit behaviour on negedge:
  - 00 hold, 01 → 0, 10 → 1, 11 → invert.
  - Reset forces all bits to 0.
- Op_In and Mask_In are sampled only at the granting edge. Later changes have no effect on the operation in flight.
- Req_In is level-sensitive and sampled only in IDLE:
  - A requester that keeps Req high after its Done issues a new request.
  - It competes again with the pointer already past it.
- Mask all-zero is a legal operation: full handshake, Q_Out unchanged.
- Op 00 is a legal operation: full handshake, Q_Out unchanged.
- Reset values: state IDLE, pointer 0, Grant_Out 0, Done_Out 0, Busy_Out 0, Q_Out 0, latched Op/Mask 0.
- Reset mid-operation aborts immediately:
  - No Done pulse is issued.
  - The bank is cleared.
  - After release, arbitration restarts with pointer 0.

## Timing
- Let edge k be the posedge at which IDLE sees a request.
  - After edge k: Grant_Out and Busy_Out go high (APPLY).
  - At the negedge inside the APPLY cycle: the bank updates and Q_Out shows the new value half a cycle after edge k.
  - After edge k+1: COMMIT; Done_Out goes high for one cycle and Grant_Out stays high.
  - After edge k+2: IDLE; Grant_Out, Done_Out and Busy_Out are low.
- The next grant can occur at edge k+3. Peak throughput is one operation per 3 cycles.
- Request-to-Done latency is 2 cycles. Each requester waits at most (NUM_REQ-1)*3 cycles before its grant.
- Grant_Out and Done_Out are registered outputs; there is no combinational path from Req_In.
- J/K are driven from registers only, so they are stable across the capturing negedge.

## Test plan
- Reset: assert Reset_In mid-cycle → all outputs 0 immediately, with no clock required. Release → Busy_Out stays 0 with no requests.
- Single set: Req[0]=1, Op=10, Mask=0x0F →
  - Grant_Out=0001 from edge k.
  - Q_Out=0x0F from the APPLY negedge.
  - Done_Out=0001 for exactly one cycle after edge k+1.
- Toggle twice: requester 2 toggles Mask=0xAA on Q=0x0F → Q_Out=0xA5; repeat the same request → Q_Out=0x0F.
- Contention: all four Req held high from reset →
  - Grants in order 0,1,2,3,0, spaced 3 cycles apart.
  - Each Done is one-hot and matches its grant.
- Late change: change Op/Mask of the granted requester during APPLY → Q_Out reflects the values sampled at the grant edge only.
- Reset mid-op: assert Reset_In during APPLY with Op=10, Mask=0xFF → no Done pulse and Q_Out=0. After release, Req[3] alone → granted, and Done_Out=1000.
